// File: rtl/branch_res_station.sv
// In-order reservation station for JAL/JALR/Bxx: holds dispatched branches, snoops the CDB
// for missing operands and issues the oldest fully-ready branch to branch_comp, one per cycle.
module branch_res_station #(
    parameter int ROB_DEPTH = 4,
    parameter int RS_DEPTH  = 4,
    localparam int TW = $clog2(ROB_DEPTH),
    localparam int PW = $clog2(RS_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          dispatch_valid,
    output logic          dispatch_ready,
    input  logic [31:0]   dispatch_instr,
    input  logic [31:0]   dispatch_pc,
    input  logic [31:0]   dispatch_imm,
    input  logic [TW-1:0] dispatch_tag,
    input  logic          rs1_rdy,
    input  logic          rs2_rdy,
    input  logic [31:0]   rs1_val,
    input  logic [31:0]   rs2_val,
    input  logic [TW-1:0] rs1_tag,
    input  logic [TW-1:0] rs2_tag,
    input  logic          cdb_valid_in,
    input  logic [TW-1:0] cdb_tag_in,
    input  logic [31:0]   cdb_data_in,
    output logic          comp_issue,
    output logic [31:0]   issue_instr,
    output logic [31:0]   issue_pc,
    output logic [31:0]   issue_imm,
    output logic [31:0]   issue_rs1_v,
    output logic [31:0]   issue_rs2_v,
    output logic [TW-1:0] issue_tag
);

    logic [RS_DEPTH-1:0] valid;
    logic [PW-1:0]       head, tail;
    logic [PW:0]         count;

    logic [31:0]   e_instr [RS_DEPTH];
    logic [31:0]   e_pc    [RS_DEPTH];
    logic [31:0]   e_imm   [RS_DEPTH];
    logic [TW-1:0] e_tag   [RS_DEPTH];
    logic          e_rdy1  [RS_DEPTH];
    logic          e_rdy2  [RS_DEPTH];
    logic [31:0]   e_val1  [RS_DEPTH];
    logic [31:0]   e_val2  [RS_DEPTH];
    logic [TW-1:0] e_src1  [RS_DEPTH];
    logic [TW-1:0] e_src2  [RS_DEPTH];

    logic dispatch_fire;
    logic issue_sel;

    assign dispatch_ready = (count != (PW+1)'(RS_DEPTH));
    assign dispatch_fire  = dispatch_valid & dispatch_ready & ~flush;
    // Select sees start-of-cycle state only; a same-cycle CDB wakeup issues one cycle later.
    assign issue_sel      = valid[head] & e_rdy1[head] & e_rdy2[head];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            comp_issue  <= 1'b0;
            issue_instr <= '0;
            issue_pc    <= '0;
            issue_imm   <= '0;
            issue_rs1_v <= '0;
            issue_rs2_v <= '0;
            issue_tag   <= '0;
        end else if (flush) begin
            valid      <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            comp_issue <= 1'b0;
        end else begin
            comp_issue <= issue_sel;
            if (issue_sel) begin
                issue_instr <= e_instr[head];
                issue_pc    <= e_pc[head];
                issue_imm   <= e_imm[head];
                issue_rs1_v <= e_val1[head];
                issue_rs2_v <= e_val2[head];
                issue_tag   <= e_tag[head];
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            // Dispatch only happens when not full, so tail never aliases a valid head.
            if (dispatch_fire) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            case ({dispatch_fire, issue_sel})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry payload is not reset; it is qualified by valid, so clearing it
    // would only add reset fan-out to a wide array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (dispatch_fire && tail == PW'(i)) begin
                e_instr[i] <= dispatch_instr;
                e_pc[i]    <= dispatch_pc;
                e_imm[i]   <= dispatch_imm;
                e_tag[i]   <= dispatch_tag;
                e_src1[i]  <= rs1_tag;
                e_src2[i]  <= rs2_tag;
                e_rdy1[i]  <= rs1_rdy | (cdb_valid_in && rs1_tag == cdb_tag_in);
                e_rdy2[i]  <= rs2_rdy | (cdb_valid_in && rs2_tag == cdb_tag_in);
                e_val1[i]  <= rs1_rdy ? rs1_val : cdb_data_in;
                e_val2[i]  <= rs2_rdy ? rs2_val : cdb_data_in;
            end else if (valid[i] && cdb_valid_in) begin
                if (!e_rdy1[i] && e_src1[i] == cdb_tag_in) begin
                    e_rdy1[i] <= 1'b1;
                    e_val1[i] <= cdb_data_in;
                end
                if (!e_rdy2[i] && e_src2[i] == cdb_tag_in) begin
                    e_rdy2[i] <= 1'b1;
                    e_val2[i] <= cdb_data_in;
                end
            end
        end
    end

endmodule
